// File: rtl/inc_dec_pkg.sv
// inc_dec_pkg: definitions shared by stream_arbiter and its round-robin picker.
//   - ASCII constants for the INC/DEC token alphabet and the word delimiters
//   - arbiter state type {IDLE, FWD, SEP}
//   - is_delim(): true for the bytes that end a word (space, LF)
package inc_dec_pkg;

    localparam logic [7:0] ASCII_I     = 8'h49;
    localparam logic [7:0] ASCII_N     = 8'h4E;
    localparam logic [7:0] ASCII_C     = 8'h43;
    localparam logic [7:0] ASCII_D     = 8'h44;
    localparam logic [7:0] ASCII_E     = 8'h45;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        SEP  = 2'd2
    } arb_state_t;

    function automatic logic is_delim(input logic [7:0] b);
        return (b == ASCII_SPACE) || (b == ASCII_LF);
    endfunction

endpackage

// File: rtl/stream_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Returns the first set bit of req, searching upward from ptr with wrap-around.
// Ports:
//   req  in   NUM_REQ          request vector
//   ptr  in   $clog2(NUM_REQ)  highest-priority index
//   idx  out  $clog2(NUM_REQ)  chosen index (0 when any is low)
//   any  out  1                at least one request is set
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);
    localparam int IDW = $clog2(NUM_REQ);

    // One extra bit holds ptr+k before the modulo fold (max 2*NUM_REQ-2).
    logic [NUM_REQ-1:0][IDW:0]   w_sum;
    logic [NUM_REQ-1:0][IDW-1:0] w_cand;
    logic [NUM_REQ-1:0]          w_hit;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_off
        assign w_sum[k]  = {1'b0, ptr} + (IDW+1)'(k);
        assign w_cand[k] = (w_sum[k] >= (IDW+1)'(NUM_REQ)) ?
                           IDW'(w_sum[k] - (IDW+1)'(NUM_REQ)) : IDW'(w_sum[k]);
        assign w_hit[k]  = req[w_cand[k]];
    end

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_hit[k]) idx = w_cand[k];
        end
    end

    assign any = |req;

endmodule

// File: rtl/stream_arbiter.sv
// stream_arbiter: round-robin sharing of one inc_dec_detector between NUM_REQ
// byte-stream requesters. A grant is held until a word delimiter so tokens are
// never split; a release without delimiter (burst limit or timeout) injects one
// 0x20 separator so a partial token cannot merge with the next stream.
// Optional feature: define STREAM_ARB_TIMEOUT_EN to release a stalled grant
// after TIMEOUT_CYC idle FWD cycles.
// Ports:
//   clk           in   1              clock, rising edge
//   rst           in   1              asynchronous reset, active low
//   req_data      in   8*NUM_REQ      byte i on [8i+7:8i]
//   req_valid     in   NUM_REQ        requester i has a byte
//   req_ready     out  NUM_REQ        byte from requester i accepted this cycle
//   out_data      out  8              byte to the detector (held when not valid)
//   out_valid     out  1              out_data valid
//   grant_id      out  $clog2(NUM_REQ) current or last granted requester
//   grant_active  out  1              arbiter is forwarding (FWD)
module stream_arbiter
    import inc_dec_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MAX_BURST   = 16,
    parameter int TIMEOUT_CYC = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       grant_active
);
    localparam int IDW = $clog2(NUM_REQ);

    arb_state_t     r_state;
    logic [IDW-1:0] r_grant_id;
    logic [IDW-1:0] r_ptr;
    logic [7:0]     r_burst_cnt;
    logic [7:0]     r_out_data;
    logic           r_out_valid;

    logic [IDW-1:0] w_pick_idx;
    logic           w_pick_any;
    logic [IDW-1:0] w_next_ptr;
    logic [7:0]     w_byte;
    logic [7:0]     w_burst_nxt;
    logic           w_xfer;
    logic           w_burst_done;
    logic           w_timeout;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req (req_valid),
        .ptr (r_ptr),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    assign w_byte       = req_data[{r_grant_id, 3'b000} +: 8];
    assign w_xfer       = (r_state == FWD) && req_valid[r_grant_id];
    assign w_burst_nxt  = (r_burst_cnt == 8'hFF) ? 8'hFF : r_burst_cnt + 8'd1;
    assign w_burst_done = (w_burst_nxt >= 8'(MAX_BURST));
    // The requester just served drops to lowest priority.
    assign w_next_ptr   = (r_grant_id == IDW'(NUM_REQ - 1)) ? '0 : r_grant_id + IDW'(1);

`ifdef STREAM_ARB_TIMEOUT_EN
    logic [7:0] r_idle_cnt;

    // Counts consecutive FWD cycles without a transfer; zero outside FWD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                              r_idle_cnt <= '0;
        else if (r_state != FWD || w_xfer)     r_idle_cnt <= '0;
        else                                   r_idle_cnt <= r_idle_cnt + 8'd1;
    end

    assign w_timeout = (r_state == FWD) && !w_xfer &&
                       ((r_idle_cnt + 8'd1) >= 8'(TIMEOUT_CYC));
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^(8'(TIMEOUT_CYC));
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_grant_id  <= '0;
            r_ptr       <= '0;
            r_burst_cnt <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_grant_id  <= w_pick_idx;
                        r_burst_cnt <= '0;
                        r_state     <= FWD;
                    end
                end
                FWD: begin
                    if (w_xfer) begin
                        r_out_data  <= w_byte;
                        r_out_valid <= 1'b1;
                        r_burst_cnt <= w_burst_nxt;
                        // A delimiter already resets the detector: no separator.
                        if (is_delim(w_byte)) begin
                            r_state <= IDLE;
                            r_ptr   <= w_next_ptr;
                        end else if (w_burst_done) begin
                            r_state <= SEP;
                            r_ptr   <= w_next_ptr;
                        end
                    end else if (w_timeout) begin
                        r_state <= SEP;
                        r_ptr   <= w_next_ptr;
                    end
                end
                SEP: begin
                    r_out_data  <= ASCII_SPACE;
                    r_out_valid <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = '0;
        if (r_state == FWD) req_ready[r_grant_id] = 1'b1;
    end

    assign out_data     = r_out_data;
    assign out_valid    = r_out_valid;
    assign grant_id     = r_grant_id;
    assign grant_active = (r_state == FWD);

endmodule

// File: tb/tb_stream_arbiter.sv
// Randomized and directed stimulus against a transaction-level model of the
// arbiter: who owns the detector, how many bytes it has sent, and whether a
// separator is owed.
module tb_stream_arbiter;
    localparam int N  = 4;
    localparam int MB = 4;
    localparam int TO = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [7:0]       out_data;
    logic             out_valid;
    logic [1:0]       grant_id;
    logic             grant_active;

    stream_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_data     (req_data),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .grant_id     (grant_id),
        .grant_active (grant_active)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Per-requester byte streams
    logic [7:0] sbuf [N][2048];
    int         shead [N];
    int         stail [N];
    int         vprob = 100;

    // Model state
    int         m_owner;   // -1: nobody holds the detector
    int         m_last;
    int         m_ptr;
    int         m_sent;
    int         m_quiet;
    bit         m_sep;
    bit         m_ov;
    logic [7:0] m_od;
    bit         prev_ga;

    logic [7:0] oq[$];
    int         gq[$];

    task automatic push(input int r, input string s);
        for (int k = 0; k < s.len(); k++) begin
            sbuf[r][stail[r]] = s[k];
            stail[r]++;
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_last = 0; m_ptr = 0; m_sent = 0; m_quiet = 0;
        m_sep = 0; m_ov = 0; m_od = 8'h00; prev_ga = 0;
    endtask

    task automatic drive_inputs();
        for (int r = 0; r < N; r++) begin
            req_valid[r]       = (shead[r] < stail[r]) && ($urandom_range(99) < vprob);
            req_data[8*r +: 8] = (shead[r] < stail[r]) ? sbuf[r][shead[r]] : 8'h00;
        end
    endtask

    task automatic release_owner(input bit sep);
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_sep   = sep;
    endtask

    // Check this cycle's outputs, then advance the model across the edge.
    task automatic step();
        logic [N-1:0] exp_rdy;
        logic [7:0]   b;
        bit           found;
        @(negedge clk);
        exp_rdy = '0;
        if (m_owner >= 0) exp_rdy[m_owner] = 1'b1;
        chk("req_ready",    32'(req_ready),    32'(exp_rdy));
        chk("grant_active", 32'(grant_active), 32'(m_owner >= 0));
        chk("grant_id",     32'(grant_id),     32'(m_last));
        chk("out_valid",    32'(out_valid),    32'(m_ov));
        chk("out_data",     32'(out_data),     32'(m_od));
        if (out_valid) oq.push_back(out_data);
        if (grant_active && !prev_ga) gq.push_back(int'(grant_id));
        prev_ga = grant_active;

        if (m_owner >= 0) begin
            if (req_valid[m_owner]) begin
                b = sbuf[m_owner][shead[m_owner]];
                shead[m_owner]++;
                m_ov = 1; m_od = b; m_sent++; m_quiet = 0;
                if (b == 8'h20 || b == 8'h0A) release_owner(0);
                else if (m_sent == MB)       release_owner(1);
            end else begin
                m_ov = 0;
`ifdef STREAM_ARB_TIMEOUT_EN
                m_quiet++;
                if (m_quiet == TO) release_owner(1);
`endif
            end
        end else if (m_sep) begin
            m_sep = 0; m_ov = 1; m_od = 8'h20;
        end else begin
            m_ov  = 0;
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && req_valid[(m_ptr + k) % N]) begin
                    found   = 1;
                    m_owner = (m_ptr + k) % N;
                    m_last  = m_owner;
                    m_sent  = 0;
                    m_quiet = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    function automatic bit drained();
        for (int r = 0; r < N; r++) if (shead[r] < stail[r]) return 0;
        return (m_owner < 0) && !m_sep && !m_ov;
    endfunction

    task automatic run_until_idle(input int budget);
        int c = 0;
        drive_inputs();
        while (!drained() && c < budget) begin
            step();
            c++;
        end
        if (!drained()) chk("drain_budget", 32'd1, 32'd0);
        else            step();
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_out_valid",    32'(out_valid),    32'd0);
        chk("rst_out_data",     32'(out_data),     32'd0);
        chk("rst_req_ready",    32'(req_ready),    32'd0);
        chk("rst_grant_id",     32'(grant_id),     32'd0);
        chk("rst_grant_active", 32'(grant_active), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive_inputs();
    endtask

    task automatic chk_stream(input string tag, input string s);
        chk({tag, "_len"}, 32'(oq.size()), 32'(s.len()));
        for (int k = 0; k < s.len() && k < oq.size(); k++)
            chk({tag, "_byte"}, 32'(oq[k]), 32'(s[k]));
    endtask

    initial begin
        string alpha;
        int    len;
        alpha = "INCDEX \n";
        for (int r = 0; r < N; r++) begin shead[r] = 0; stail[r] = 0; end
        req_data  = '0;
        req_valid = '0;
        model_reset();
        #2;
        do_reset();

        // "INC " on requester 0: delimiter arrives exactly at MAX_BURST -> no SEP
        oq.delete(); gq.delete();
        push(0, "INC ");
        run_until_idle(50);
        chk_stream("t1", "INC ");
        chk("t1_grants", 32'(gq.size()), 32'd1);

        // One LF per requester, two on requester 0: round-robin order 0,1,2,3,0
        do_reset();
        oq.delete(); gq.delete();
        push(0, "\n\n"); push(1, "\n"); push(2, "\n"); push(3, "\n");
        run_until_idle(50);
        chk("t2_grants", 32'(gq.size()), 32'd5);
        for (int k = 0; k < gq.size() && k < 5; k++)
            chk("t2_order", 32'(gq[k]), 32'(k % 4));

        // Undelimited stream hits MAX_BURST -> separator, grant moves on
        do_reset();
        oq.delete(); gq.delete();
        push(1, "INCINCINC ");
        push(2, "DEC ");
        run_until_idle(100);
        chk_stream("t3", "INCI DEC NCIN C ");
        chk("t3_grants", 32'(gq.size()), 32'd4);
        if (gq.size() >= 2) chk("t3_second", 32'(gq[1]), 32'd2);

`ifdef STREAM_ARB_TIMEOUT_EN
        // Stalled requester released by timeout, followed by a separator
        do_reset();
        oq.delete(); gq.delete();
        push(2, "DE");
        run_until_idle(50);
        push(3, "C ");
        run_until_idle(50);
        chk_stream("t4", "DE C ");
`endif

        // Reset mid-burst, then first grant goes to lowest valid index
        do_reset();
        vprob = 100;
        push(3, "DECDEC ");
        drive_inputs();
        for (int k = 0; k < 4; k++) step();
        push(1, "I\n");
        do_reset();
        oq.delete(); gq.delete();
        run_until_idle(100);
        if (gq.size() > 0) chk("t5_first", 32'(gq[0]), 32'd1);
        else               chk("t5_first", 32'd99, 32'd1);

        // Random streams, each ending in a delimiter, with random valid gaps
        vprob = 70;
        for (int round = 0; round < 6; round++) begin
            for (int r = 0; r < N; r++) begin
                len = $urandom_range(12);
                for (int k = 0; k < len; k++) begin
                    sbuf[r][stail[r]] = alpha[$urandom_range(alpha.len() - 1)];
                    stail[r]++;
                end
                sbuf[r][stail[r]] = ($urandom_range(1) != 0) ? 8'h20 : 8'h0A;
                stail[r]++;
            end
            run_until_idle(2000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
